// File: rtl/mlp_loader_pkg.sv
// mlp_loader_pkg
//   Shared types and default sizing for the printed-MLP feature loader.
//   state_t     : loader FSM state encoding (2 bits)
//   DEF_*       : default feature count, feature width, class width,
//                 settle time and flat classifier vector width
package mlp_loader_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int DEF_N_FEAT     = 11;
  localparam int DEF_FEAT_W     = 4;
  localparam int DEF_CLASS_W    = 3;
  localparam int DEF_SETTLE_CYC = 2;
  localparam int DEF_VEC_W      = DEF_N_FEAT * DEF_FEAT_W;

endpackage

// File: rtl/mlp_feature_loader.sv
// mlp_feature_loader
//   Sequential wrapper around a combinational printed-MLP classifier core.
//   Collects N_FEAT features from a valid/ready stream, presents them as one
//   registered flat vector to the classifier, waits SETTLE_CYC cycles for the
//   core to settle, captures the class index and offers it on a valid/ready
//   result port.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   feat_valid/feat_ready  feature stream handshake
//   feat_data              feature value, feature 0 first
//   clf_inp                registered vector to the classifier core
//                          (feature k at bits [k*FEAT_W +: FEAT_W])
//   clf_out                class index from the classifier core
//   res_valid/res_ready    result handshake
//   res_class              captured class index
//   busy                   high while not idle in LOAD with an empty stage
//
// Build option
//   MLP_LOADER_OVERLAP_EN  when defined, features 0..N_FEAT-2 of the next
//                          vector may be staged during SETTLE and RESULT.
//
// State   | meaning
// --------+-------------------------------------------------------------
// LOAD    | accepting features; the last one loads clf_inp
// SETTLE  | clf_inp held stable while the classifier settles
// RESULT  | captured class presented until the consumer takes it
module mlp_feature_loader
  import mlp_loader_pkg::*;
#(
  parameter int N_FEAT     = DEF_N_FEAT,
  parameter int FEAT_W     = DEF_FEAT_W,
  parameter int CLASS_W    = DEF_CLASS_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       feat_valid,
  input  logic [FEAT_W-1:0]          feat_data,
  output logic                       feat_ready,
  output logic [N_FEAT*FEAT_W-1:0]   clf_inp,
  input  logic [CLASS_W-1:0]         clf_out,
  output logic                       res_valid,
  output logic [CLASS_W-1:0]         res_class,
  input  logic                       res_ready,
  output logic                       busy
);

  localparam int STG_W = (N_FEAT - 1) * FEAT_W;
  localparam int IDX_W = $clog2(N_FEAT);
  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE_CYC);

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   feat_idx;
  logic [CNT_W-1:0]   settle_cnt;
  logic [STG_W-1:0]   staging;

  logic               feat_hs;
  logic               res_hs;
  logic               last_feat;
  logic               settle_done;

  assign feat_hs     = feat_valid & feat_ready;
  assign res_hs      = res_valid & res_ready;
  assign last_feat   = (feat_idx == IDX_LAST);
  assign settle_done = (state == SETTLE) && (settle_cnt == CNT_LAST);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: begin
        if (feat_hs && last_feat) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == CNT_LAST) begin
          state_nxt = RESULT;
        end
      end
      RESULT: begin
        if (res_hs) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // FSM: outputs
  always_comb begin
    feat_ready = 1'b0;
    case (state)
      LOAD: feat_ready = 1'b1;
      default: begin
`ifdef MLP_LOADER_OVERLAP_EN
        // Only pre-stage; the last feature must wait for LOAD so that
        // clf_inp never moves under an in-flight inference.
        feat_ready = (feat_idx < IDX_LAST);
`else
        feat_ready = 1'b0;
`endif
      end
    endcase
  end

  assign busy = (state != LOAD) || (feat_idx != '0);

  // Datapath: staging, classifier vector, settle timer, result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      feat_idx   <= '0;
      settle_cnt <= '0;
      staging    <= '0;
      clf_inp    <= '0;
      res_class  <= '0;
      res_valid  <= 1'b0;
    end else begin
      // feat_ready is low for the last slot outside LOAD, so a last-feature
      // handshake can only occur in LOAD.
      if (feat_hs) begin
        if (last_feat) begin
          clf_inp  <= {feat_data, staging};
          feat_idx <= '0;
        end else begin
          staging[int'(feat_idx) * FEAT_W +: FEAT_W] <= feat_data;
          feat_idx <= feat_idx + IDX_W'(1);
        end
      end

      if (feat_hs && last_feat) begin
        settle_cnt <= '0;
      end else if ((state == SETTLE) && (settle_cnt != CNT_MAX)) begin
        settle_cnt <= settle_cnt + CNT_W'(1);
      end

      if (settle_done) begin
        res_class <= clf_out;
        res_valid <= 1'b1;
      end else if (res_hs) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
